// File: rtl/stats_fifo_sync.sv
// rtl/stats_fifo_sync.sv - single-clock statistics FIFO with fill flags, full policy and loss counter
// First-word-fall-through: rdata shows the head entry whenever the FIFO is not empty.
module stats_fifo_sync #(
  parameter int DWIDTH    = 14,
  parameter int AWIDTH    = 4,
  parameter int AE_THRESH = 7,
  parameter int AF_THRESH = 12,
  parameter int OVERWRITE = 0,
  parameter int CWIDTH    = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              clr,
  input  logic              wen,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              ren,
  output logic [DWIDTH-1:0] rdata,
  output logic              rempty,
  output logic              wfull,
  output logic              ralmost_empty,
  output logic              walmost_full,
  output logic [AWIDTH:0]   level,
  output logic [CWIDTH-1:0] drop_cnt,
  output logic              ovf
);

  localparam int              DEPTH   = 1 << AWIDTH;
  localparam logic [AWIDTH:0] DEPTH_L = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0] AE_L    = (AWIDTH+1)'(AE_THRESH);
  localparam logic [AWIDTH:0] AF_L    = (AWIDTH+1)'(AF_THRESH);
  localparam logic [AWIDTH:0] ONE_L   = (AWIDTH+1)'(1);
  localparam logic [CWIDTH-1:0] CONE  = CWIDTH'(1);

  logic [DWIDTH-1:0] mem [DEPTH];

  logic [AWIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [AWIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [AWIDTH:0]   level_q, level_d;
  logic [CWIDTH-1:0] drop_q, drop_d;
  logic              ovf_q, ovf_d;
  logic              rempty_q, wfull_q, ae_q, af_q;
  logic              push, pop, lose;

  always_comb begin
    push     = 1'b0;
    pop      = 1'b0;
    lose     = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    drop_d   = drop_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      drop_d   = '0;
    end else begin
      if (wen && ren && !rempty_q) begin
        push = 1'b1;
        pop  = 1'b1;
      end else if (wen && !wfull_q) begin
        push = 1'b1;
      end else if (wen) begin
        // Full: either discard the new word or evict the oldest to make room.
        lose = 1'b1;
        if (OVERWRITE != 0) begin
          push = 1'b1;
          pop  = 1'b1;
        end
      end else if (ren && !rempty_q) begin
        pop = 1'b1;
      end
      if (push) wr_ptr_d = wr_ptr_q + ONE_L;
      if (pop)  rd_ptr_d = rd_ptr_q + ONE_L;
      if (push && !pop) level_d = level_q + ONE_L;
      if (pop && !push) level_d = level_q - ONE_L;
      if (lose && (drop_q != '1)) drop_d = drop_q + CONE;
    end
    ovf_d = lose;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
      rempty_q <= 1'b1;
      wfull_q  <= 1'b0;
      ae_q     <= 1'b1;
      af_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
      rempty_q <= (level_d == '0);
      wfull_q  <= (level_d == DEPTH_L);
      ae_q     <= (level_d <= AE_L);
      af_q     <= (level_d >= AF_L);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push && !wb_rst_i) mem[wr_ptr_q[AWIDTH-1:0]] <= wdata;
  end

  assign rdata         = rempty_q ? '0 : mem[rd_ptr_q[AWIDTH-1:0]];
  assign rempty        = rempty_q;
  assign wfull         = wfull_q;
  assign ralmost_empty = ae_q;
  assign walmost_full  = af_q;
  assign level         = level_q;
  assign drop_cnt      = drop_q;
  assign ovf           = ovf_q;

endmodule

// File: tb/tb_stats_fifo_sync.sv
// tb/tb_stats_fifo_sync.sv - self-checking bench for stats_fifo_sync
// Three instances share stimulus: drop-newest, overwrite-oldest, and drop-newest with a 2-bit loss counter.
module tb_stats_fifo_sync;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        wen = 1'b0;
  logic        ren = 1'b0;
  logic [13:0] wdata = '0;

  logic [13:0] rdata_w [3];
  logic        empty_w [3];
  logic        full_w  [3];
  logic        ae_w    [3];
  logic        af_w    [3];
  logic [4:0]  level_w [3];
  logic        ovf_w   [3];
  logic [15:0] drop0, drop1;
  logic [1:0]  drop2;

  always #5 clk = ~clk;

  stats_fifo_sync #(.OVERWRITE(0)) dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .clr(clr), .wen(wen), .wdata(wdata), .ren(ren),
    .rdata(rdata_w[0]), .rempty(empty_w[0]), .wfull(full_w[0]), .ralmost_empty(ae_w[0]),
    .walmost_full(af_w[0]), .level(level_w[0]), .drop_cnt(drop0), .ovf(ovf_w[0]));

  stats_fifo_sync #(.OVERWRITE(1)) dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .clr(clr), .wen(wen), .wdata(wdata), .ren(ren),
    .rdata(rdata_w[1]), .rempty(empty_w[1]), .wfull(full_w[1]), .ralmost_empty(ae_w[1]),
    .walmost_full(af_w[1]), .level(level_w[1]), .drop_cnt(drop1), .ovf(ovf_w[1]));

  stats_fifo_sync #(.OVERWRITE(0), .CWIDTH(2)) dut2 (
    .wb_clk_i(clk), .wb_rst_i(rst), .clr(clr), .wen(wen), .wdata(wdata), .ren(ren),
    .rdata(rdata_w[2]), .rempty(empty_w[2]), .wfull(full_w[2]), .ralmost_empty(ae_w[2]),
    .walmost_full(af_w[2]), .level(level_w[2]), .drop_cnt(drop2), .ovf(ovf_w[2]));

  int errors = 0;
  int checks = 0;

  // Reference model: each FIFO is a plain queue plus a loss tally.
  logic [13:0] mq [3][$];
  int          mdrop [3];
  logic        movf  [3];
  int          ow    [3] = '{0, 1, 0};
  int          cmax  [3] = '{65535, 65535, 3};

  typedef struct {
    logic        w, r, c;
    logic [13:0] d;
    int          lvl;
    logic [13:0] rd;
    logic        emp;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int drop_of(input int i);
    if (i == 0) return int'(drop0);
    if (i == 1) return int'(drop1);
    return int'(drop2);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mq[i].delete();
      mdrop[i] = 0;
      movf[i]  = 1'b0;
    end
  endtask

  task automatic model_update(input logic w, input logic r, input logic c, input logic [13:0] d);
    for (int i = 0; i < 3; i++) begin
      movf[i] = 1'b0;
      if (c) begin
        mq[i].delete();
        mdrop[i] = 0;
      end else if (w) begin
        if (mq[i].size() == 16 && !r) begin
          movf[i] = 1'b1;
          if (mdrop[i] < cmax[i]) mdrop[i]++;
          if (ow[i] != 0) begin
            void'(mq[i].pop_front());
            mq[i].push_back(d);
          end
        end else begin
          if (r && mq[i].size() > 0) void'(mq[i].pop_front());
          mq[i].push_back(d);
        end
      end else if (r && mq[i].size() > 0) begin
        void'(mq[i].pop_front());
      end
    end
  endtask

  task automatic model_check();
    for (int i = 0; i < 3; i++) begin
      int n;
      n = mq[i].size();
      chk($sformatf("m%0d_level", i), int'(level_w[i]), n);
      chk($sformatf("m%0d_rdata", i), int'(rdata_w[i]), (n > 0) ? int'(mq[i][0]) : 0);
      chk($sformatf("m%0d_rempty", i), int'(empty_w[i]), int'(n == 0));
      chk($sformatf("m%0d_wfull", i), int'(full_w[i]), int'(n == 16));
      chk($sformatf("m%0d_ae", i), int'(ae_w[i]), int'(n <= 7));
      chk($sformatf("m%0d_af", i), int'(af_w[i]), int'(n >= 12));
      chk($sformatf("m%0d_drop", i), drop_of(i), mdrop[i]);
      chk($sformatf("m%0d_ovf", i), int'(ovf_w[i]), int'(movf[i]));
    end
  endtask

  task automatic step(input logic w, input logic r, input logic c, input logic [13:0] d);
    wen = w; ren = r; clr = c; wdata = d;
    @(posedge clk);
    model_update(w, r, c, d);
    #1;
    model_check();
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 14'h0001, 1, 14'h0001, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 14'h0002, 2, 14'h0001, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 14'h0003, 3, 14'h0001, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 14'h0000, 2, 14'h0002, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 14'h0000, 1, 14'h0003, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 14'h0000, 0, 14'h0000, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 14'h0000, 0, 14'h0000, 1'b1};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 14'h0055, 1, 14'h0055, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 14'h0000, 0, 14'h0000, 1'b1};

    model_reset();
    #12;
    model_check();
    chk("reset_rempty", int'(empty_w[0]), 1);
    chk("reset_ae", int'(ae_w[0]), 1);
    @(negedge clk);
    rst = 1'b0;

    // Basic push/pop latency and empty-read behaviour.
    for (int k = 0; k < 9; k++) begin
      step(tbl[k].w, tbl[k].r, tbl[k].c, tbl[k].d);
      chk($sformatf("tbl%0d_level", k), int'(level_w[0]), tbl[k].lvl);
      chk($sformatf("tbl%0d_rdata", k), int'(rdata_w[0]), int'(tbl[k].rd));
      chk($sformatf("tbl%0d_rempty", k), int'(empty_w[0]), int'(tbl[k].emp));
    end

    // Fill to DEPTH watching the threshold flags, then overflow by two.
    step(1'b0, 1'b0, 1'b1, 14'h0);
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b0, 1'b0, 14'(14'h100 + i));
      chk($sformatf("fill%0d_ae", i), int'(ae_w[0]), int'(i <= 7));
      chk($sformatf("fill%0d_af", i), int'(af_w[0]), int'(i >= 12));
      chk($sformatf("fill%0d_full", i), int'(full_w[0]), int'(i == 16));
    end
    step(1'b1, 1'b0, 1'b0, 14'h111);
    chk("drop17_cnt0", drop_of(0), 1);
    chk("drop17_ovf0", int'(ovf_w[0]), 1);
    chk("drop17_rdata0", int'(rdata_w[0]), 14'h101);
    chk("ovw17_rdata1", int'(rdata_w[1]), 14'h102);
    step(1'b1, 1'b0, 1'b0, 14'h112);
    chk("ovw18_level1", int'(level_w[1]), 16);
    chk("ovw18_cnt1", drop_of(1), 2);
    chk("ovw18_rdata1", int'(rdata_w[1]), 14'h103);
    step(1'b0, 1'b0, 1'b0, 14'h0);
    chk("ovf_single_cycle", int'(ovf_w[0]), 0);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("ovw_order%0d", k), int'(rdata_w[1]), 14'h103 + k);
      step(1'b0, 1'b1, 1'b0, 14'h0);
    end
    chk("ovw_drained", int'(empty_w[1]), 1);

    // Simultaneous push and pop when full and when empty.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 14'(14'h200 + i));
    step(1'b1, 1'b1, 1'b0, 14'h3AA);
    chk("full_wr_level", int'(level_w[0]), 16);
    chk("full_wr_ovf0", int'(ovf_w[0]), 0);
    chk("full_wr_ovf1", int'(ovf_w[1]), 0);
    step(1'b0, 1'b0, 1'b1, 14'h0);
    step(1'b1, 1'b1, 1'b0, 14'h2BC);
    chk("empty_wr_level", int'(level_w[0]), 1);
    chk("empty_wr_rdata", int'(rdata_w[0]), 14'h2BC);

    // Saturating 2-bit loss counter, then clear with a concurrent write.
    step(1'b0, 1'b0, 1'b1, 14'h0);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 14'(i));
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, 1'b0, 14'h3FF);
      chk($sformatf("sat%0d_cnt", k), drop_of(2), (k < 3) ? k + 1 : 3);
      chk($sformatf("sat%0d_ovf", k), int'(ovf_w[2]), 1);
    end
    step(1'b1, 1'b0, 1'b1, 14'h155);
    chk("clr_level", int'(level_w[2]), 0);
    chk("clr_drop", drop_of(2), 0);
    chk("clr_rempty", int'(empty_w[2]), 1);

    // Asynchronous reset between edges with the FIFO part-full.
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, 14'(14'h50 + i));
    chk("pre_rst_level", int'(level_w[0]), 9);
    wen = 1'b1; wdata = 14'h77;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    model_check();
    chk("async_rst_level", int'(level_w[0]), 0);
    chk("async_rst_rdata", int'(rdata_w[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    wen = 1'b0;

    // Random traffic alternating between fill-heavy and drain-heavy phases.
    for (int n = 0; n < 2000; n++) begin
      int wp;
      wp = ((n / 150) % 2 == 0) ? 80 : 30;
      step(1'(($urandom_range(0, 99)) < wp), 1'(($urandom_range(0, 99)) < 45),
           1'($urandom_range(0, 199) == 0), 14'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
